// File: rtl/addpkg.sv
// Shared constants, stage record layout and level-split helper for the FP alignment shifter.
package addpkg;

    localparam int unsigned SIG_W_DEF = 27;
    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned TAG_W_DEF = 4;
    localparam int unsigned LVL_DEF   = $clog2(SIG_W_DEF);

    // Per-stage register contents for the default configuration.
    typedef struct packed {
        logic                 valid;
        logic [SIG_W_DEF-1:0] sig1;
        logic [SIG_W_DEF-1:0] partial;
        logic                 sticky;
        logic [LVL_DEF-1:0]   shift;
        logic [TAG_W_DEF-1:0] tag;
    } align_stage_t;

    // First shift level handled by stage s: ceil(s*lvl/stages).
    function automatic int unsigned lvl_lo(input int unsigned s, input int unsigned lvl,
                                           input int unsigned stages);
        return (s * lvl + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/align_shift_level.sv
// One log-shifter level: optional right shift by AMT, collecting lost bits into sticky.
module align_shift_level #(
    parameter int unsigned SIG_W = 27,
    parameter int unsigned AMT   = 1
) (
    input  logic [SIG_W-1:0] data,
    input  logic             en,
    input  logic             sticky_in,
    output logic [SIG_W-1:0] data_out,
    output logic             sticky_out
);

    // Shift when enabled and OR any discarded low bits into the running sticky.
    always_comb begin
        data_out   = data;
        sticky_out = sticky_in;
        if (en) begin
            data_out   = data >> AMT;
            sticky_out = sticky_in | (|data[AMT-1:0]);
        end
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Pipelined significand alignment shifter with sticky collection, saturation and
// valid/ready flow control. Shift levels are spread evenly over STAGES registers.
module fp_align_pipe
    import addpkg::*;
#(
    parameter int unsigned SIG_W  = SIG_W_DEF,
    parameter int unsigned EXP_W  = EXP_W_DEF,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] in_sig1,
    input  logic [SIG_W-1:0] in_sig2,
    input  logic [EXP_W-1:0] in_shift,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig1,
    output logic [SIG_W-1:0] out_sig2_aligned,
    output logic             out_sticky,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LVL = $clog2(SIG_W);

    typedef struct packed {
        logic             valid;
        logic [SIG_W-1:0] sig1;
        logic [SIG_W-1:0] partial;
        logic             sticky;
        logic [LVL-1:0]   shift;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           pipe_q     [STAGES];
    logic             stg_valid  [STAGES];
    logic [SIG_W-1:0] stg_sig1   [STAGES];
    logic [SIG_W-1:0] stg_data   [STAGES];
    logic             stg_sticky [STAGES];
    logic [LVL-1:0]   stg_shift  [STAGES];
    logic [TAG_W-1:0] stg_tag    [STAGES];
    logic [SIG_W-1:0] lvl_data   [LVL];
    logic             lvl_sticky [LVL];
    logic             adv;
    logic             sat;
    logic             unused_last_shift;

    // The whole pipe moves together; it only stalls when the output is held.
    assign adv      = !pipe_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    // Saturation looks at the full shift value, not just the LVL bits the shifter uses.
    assign sat = 32'(in_shift) >= SIG_W;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned Lo = lvl_lo(s, LVL, STAGES);
        localparam int unsigned Hi = lvl_lo(s + 1, LVL, STAGES);

        stage_t stage_q;
        stage_t stage_d;
        logic   unused_shift_bits;

        if (s == 0) begin : g_head
            // A saturated request enters as zero with sticky already resolved and no shift left.
            assign stg_valid[s]  = in_valid;
            assign stg_sig1[s]   = in_sig1;
            assign stg_data[s]   = sat ? '0 : in_sig2;
            assign stg_sticky[s] = sat & (|in_sig2);
            assign stg_shift[s]  = sat ? '0 : in_shift[LVL-1:0];
            assign stg_tag[s]    = in_tag;
        end else begin : g_body
            assign stg_valid[s]  = pipe_q[s-1].valid;
            assign stg_sig1[s]   = pipe_q[s-1].sig1;
            assign stg_data[s]   = pipe_q[s-1].partial;
            assign stg_sticky[s] = pipe_q[s-1].sticky;
            assign stg_shift[s]  = pipe_q[s-1].shift;
            assign stg_tag[s]    = pipe_q[s-1].tag;
        end

        for (genvar k = Lo; k < Hi; k++) begin : g_lvl
            logic [SIG_W-1:0] din;
            logic             sin;

            if (k == Lo) begin : g_first
                assign din = stg_data[s];
                assign sin = stg_sticky[s];
            end else begin : g_chain
                assign din = lvl_data[k-1];
                assign sin = lvl_sticky[k-1];
            end

            align_shift_level #(
                .SIG_W (SIG_W),
                .AMT   (1 << k)
            ) u_level (
                .data       (din),
                .en         (stg_shift[s][k]),
                .sticky_in  (sin),
                .data_out   (lvl_data[k]),
                .sticky_out (lvl_sticky[k])
            );
        end

        // Load on advance (bubbles included), otherwise hold.
        always_comb begin
            stage_d = stage_q;
            if (adv) begin
                stage_d.valid   = stg_valid[s];
                stage_d.sig1    = stg_sig1[s];
                stage_d.partial = lvl_data[Hi-1];
                stage_d.sticky  = lvl_sticky[Hi-1];
                stage_d.shift   = stg_shift[s];
                stage_d.tag     = stg_tag[s];
            end
        end

        // Stage register; reset discards anything in flight.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign pipe_q[s] = stage_q;
        // Shift bits consumed by earlier stages are carried but not needed here.
        assign unused_shift_bits = ^stg_shift[s];
    end

    assign unused_last_shift = ^pipe_q[STAGES-1].shift;

    assign out_valid        = pipe_q[STAGES-1].valid;
    assign out_sig1         = pipe_q[STAGES-1].sig1;
    assign out_sticky       = pipe_q[STAGES-1].sticky;
    assign out_sig2_aligned = pipe_q[STAGES-1].partial | {{(SIG_W-1){1'b0}}, pipe_q[STAGES-1].sticky};
    assign out_tag          = pipe_q[STAGES-1].tag;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed and random checks of fp_align_pipe, run on a 1-stage and a 3-stage instance.
module tb_fp_align_pipe;

    localparam int SW = 27;
    localparam int EW = 8;
    localparam int TW = 4;
    localparam int NRAND = 5000;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          st;
        logic [SW-1:0] al;
        logic [SW-1:0] s1;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic [SW-1:0] in_sig1;
    logic [SW-1:0] in_sig2;
    logic [EW-1:0] in_shift;
    logic [TW-1:0] in_tag;

    logic          iv_a, ir_a, ov_a, os_a;
    logic          iv_b, ir_b, ov_b, os_b;
    logic [SW-1:0] s1_a, al_a, s1_b, al_b;
    logic [TW-1:0] t_a, t_b;

    logic          o_valid, o_in_ready, o_st;
    logic [SW-1:0] o_s1, o_al;
    logic [TW-1:0] o_tag;

    int sel = 0;
    int stages = 1;
    int total = 0;
    int bad = 0;

    exp_t exq[$];
    exp_t e;
    exp_t prev;
    int   have_prev;
    int   sent;
    int   got;
    int   n;
    int   seen;

    always #5 clk = ~clk;

    assign iv_a = in_valid && (sel == 0);
    assign iv_b = in_valid && (sel != 0);

    assign o_valid    = (sel != 0) ? ov_b : ov_a;
    assign o_in_ready = (sel != 0) ? ir_b : ir_a;
    assign o_st       = (sel != 0) ? os_b : os_a;
    assign o_s1       = (sel != 0) ? s1_b : s1_a;
    assign o_al       = (sel != 0) ? al_b : al_a;
    assign o_tag      = (sel != 0) ? t_b : t_a;

    fp_align_pipe #(.SIG_W(SW), .EXP_W(EW), .STAGES(1), .TAG_W(TW)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .in_sig1(in_sig1),
        .in_sig2(in_sig2), .in_shift(in_shift), .in_tag(in_tag), .out_valid(ov_a),
        .out_ready(out_ready), .out_sig1(s1_a), .out_sig2_aligned(al_a), .out_sticky(os_a),
        .out_tag(t_a)
    );

    fp_align_pipe #(.SIG_W(SW), .EXP_W(EW), .STAGES(3), .TAG_W(TW)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .in_sig1(in_sig1),
        .in_sig2(in_sig2), .in_shift(in_shift), .in_tag(in_tag), .out_valid(ov_b),
        .out_ready(out_ready), .out_sig1(s1_b), .out_sig2_aligned(al_b), .out_sticky(os_b),
        .out_tag(t_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s stages=%0d observed=%0h expected=%0h", tag, stages, obs, expv);
        end
    endtask

    // Reference: plain shift, sticky = any set bit below the shift amount.
    function automatic exp_t ref_model(input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                                       input logic [EW-1:0] sh, input logic [TW-1:0] tg);
        exp_t r;
        r.s1  = s1;
        r.tag = tg;
        if (int'(sh) >= SW) begin
            r.st = |s2;
            r.al = '0;
        end else begin
            r.st = 1'b0;
            for (int i = 0; i < SW; i++) begin
                if (i < int'(sh) && s2[i]) r.st = 1'b1;
            end
            r.al = s2 >> sh;
        end
        r.al[0] = r.al[0] | r.st;
        return r;
    endfunction

    task automatic drive(input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                         input logic [EW-1:0] sh, input logic [TW-1:0] tg);
        in_sig1  = s1;
        in_sig2  = s2;
        in_shift = sh;
        in_tag   = tg;
    endtask

    task automatic directed(input string name, input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                            input logic [EW-1:0] sh, input logic [TW-1:0] tg,
                            input logic [SW-1:0] exp_al, input logic exp_st);
        @(negedge clk);
        drive(s1, s2, sh, tg);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_lat"}, 64'(n), 64'(stages));
        chk({name, "_al"}, 64'(o_al), 64'(exp_al));
        chk({name, "_st"}, 64'(o_st), 64'(exp_st));
        chk({name, "_s1"}, 64'(o_s1), 64'(s1));
        chk({name, "_tag"}, 64'(o_tag), 64'(tg));
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (stages + 2) @(posedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive('0, '0, '0, '0);

        for (int p = 0; p < 2; p++) begin
            sel    = p;
            stages = (p != 0) ? 3 : 1;

            // Reset state
            @(negedge clk);
            reset = 1'b1;
            #1;
            chk("rst_out_valid", 64'(o_valid), 64'd0);
            chk("rst_out_al", 64'(o_al), 64'd0);
            chk("rst_out_tag", 64'(o_tag), 64'd0);
            @(negedge clk);
            reset = 1'b0;
            #1 chk("rst_in_ready", 64'(o_in_ready), 64'd1);

            // Directed vectors
            directed("sh3", 27'h0123456, 27'h4000000, 8'd3, 4'h1, 27'h0800000, 1'b0);
            directed("sh2_exact", 27'h7FFFFFF, 27'h4000004, 8'd2, 4'h2, 27'h1000001, 1'b0);
            directed("sh2_sticky", 27'h0000001, 27'h4000002, 8'd2, 4'h3, 27'h1000001, 1'b1);
            directed("sat200", 27'h5555555, 27'h4000000, 8'd200, 4'h4, 27'h0000001, 1'b1);
            directed("sat_zero", 27'h2AAAAAA, 27'h0000000, 8'd200, 4'h5, 27'h0000000, 1'b0);
            directed("sat27", 27'h0000F00, 27'h4000000, 8'd27, 4'h6, 27'h0000001, 1'b1);
            directed("sh0", 27'h1111111, 27'h5A5A5A5, 8'd0, 4'h7, 27'h5A5A5A5, 1'b0);
            directed("sh26_msb", 27'h0000002, 27'h4000000, 8'd26, 4'h8, 27'h0000001, 1'b0);
            directed("sh26_all", 27'h0000003, 27'h7FFFFFF, 8'd26, 4'h9, 27'h0000001, 1'b1);
            directed("sh26_low", 27'h0000004, 27'h3FFFFFF, 8'd26, 4'hA, 27'h0000001, 1'b1);
            directed("sh255_zero", 27'h0000005, 27'h0000000, 8'd255, 4'hB, 27'h0000000, 1'b0);
            directed("sh5_zero", 27'h0000006, 27'h0000000, 8'd5, 4'hC, 27'h0000000, 1'b0);
            drain();

            // Back-to-back stream with a stall window
            sent = 0;
            got = 0;
            have_prev = 0;
            exq.delete();
            for (int c = 0; c < 60 && got < 10; c++) begin
                @(negedge clk);
                out_ready = !(c >= 4 && c <= 8);
                if (sent < 10) begin
                    drive(27'(sent * 32'h111111), 27'(32'h5A5A5A5 ^ (sent * 32'h0031337)),
                          8'(sent * 3), 4'(sent));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (o_valid && !out_ready) begin
                    chk("stall_in_ready", 64'(o_in_ready), 64'd0);
                    if (have_prev != 0) begin
                        chk("stall_stable", 64'({o_tag, o_st, o_al, o_s1}), 64'(prev));
                    end
                    prev = {o_tag, o_st, o_al, o_s1};
                    have_prev = 1;
                end else begin
                    have_prev = 0;
                end
                if (o_valid && out_ready) begin
                    if (exq.size() == 0) begin
                        chk("stream_extra", 64'd1, 64'd0);
                    end else begin
                        e = exq.pop_front();
                        chk("stream_tag", 64'(o_tag), 64'(e.tag));
                        chk("stream_al", 64'(o_al), 64'(e.al));
                        chk("stream_st", 64'(o_st), 64'(e.st));
                        chk("stream_s1", 64'(o_s1), 64'(e.s1));
                    end
                    got++;
                end
                if (in_valid && o_in_ready) begin
                    exq.push_back(ref_model(in_sig1, in_sig2, in_shift, in_tag));
                    sent++;
                end
            end
            in_valid = 1'b0;
            chk("stream_count", 64'(got), 64'd10);

            // Asynchronous reset with three requests in flight
            out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                drive(27'h1234567, 27'h7654321, 8'(i), 4'(i + 12));
                in_valid = 1'b1;
            end
            @(posedge clk);
            #3 reset = 1'b1;
            #1;
            chk("async_rst_valid", 64'(o_valid), 64'd0);
            chk("async_rst_ready", 64'(o_in_ready), 64'd1);
            in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            #1 chk("post_rst_ready", 64'(o_in_ready), 64'd1);
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (o_valid) seen = 1;
            end
            chk("post_rst_no_stale", 64'(seen), 64'd0);

            // Random traffic against the reference model
            sent = 0;
            got = 0;
            exq.delete();
            for (int c = 0; c < 4 * NRAND + 100 && got < NRAND; c++) begin
                @(negedge clk);
                out_ready = ($urandom_range(0, 3) != 0);
                if (sent < NRAND && $urandom_range(0, 3) != 0) begin
                    drive(27'($urandom), ($urandom_range(0, 7) == 0) ? 27'd0 : 27'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31)),
                          4'($urandom));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (o_valid && out_ready) begin
                    if (exq.size() == 0) begin
                        chk("rand_extra", 64'd1, 64'd0);
                    end else begin
                        e = exq.pop_front();
                        chk("rand_tag", 64'(o_tag), 64'(e.tag));
                        chk("rand_al", 64'(o_al), 64'(e.al));
                        chk("rand_st", 64'(o_st), 64'(e.st));
                        chk("rand_s1", 64'(o_s1), 64'(e.s1));
                    end
                    got++;
                end
                if (in_valid && o_in_ready) begin
                    exq.push_back(ref_model(in_sig1, in_sig2, in_shift, in_tag));
                    sent++;
                end
            end
            in_valid = 1'b0;
            chk("rand_count", 64'(got), 64'(NRAND));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Pipelined, parametrised significand alignment shifter for the FP add/sub datapath.
- Sits after the exponent compare/swap stage and before the significand adder.
- Right-shifts the smaller-exponent significand (sig2) by the exponent difference and passes sig1 through unchanged.
- Beyond a plain shifter, it adds sticky-bit collection, saturation for oversized shifts, a configurable number of pipeline stages, and valid/ready flow control with a pass-through tag.

Parameters:
- SIG_W, 27: significand width including hidden bit and G/R/S bits.
- EXP_W, 8: width of the shift amount (exponent difference).
- STAGES, 1: number of registered pipeline stages, legal range 1..LVL. LVL = $clog2(SIG_W) shift levels.
- TAG_W, 4: width of the opaque sideband tag carried alongside the data.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: request valid.
- in_ready, output, 1: block can accept a request this cycle.
- in_sig1, input, SIG_W: larger-exponent significand, passed through.
- in_sig2, input, SIG_W: significand to align.
- in_shift, input, EXP_W: right-shift amount, unsigned.
- in_tag, input, TAG_W: sideband tag, passed through.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_sig1, output, SIG_W: registered copy of in_sig1.
- out_sig2_aligned, output, SIG_W: shifted sig2, with sticky ORed into bit 0.
- out_sticky, output, 1: 1 if any nonzero bit was shifted out.
- out_tag, output, TAG_W: registered copy of in_tag.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits clear to 0, so out_valid=0. All data and tag registers clear to 0. Reset may assert mid-operation; every in-flight request is discarded with no partial output.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
- On an accept (in_valid && in_ready), the request enters stage 0.
- When adv=0, every stage holds its contents; outputs stay stable while out_valid=1 && !out_ready.
- Bubbles are not collapsed. A stage with valid=0 still advances when adv=1.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready stays high. Throughput: 1 result per cycle.
- Shift arithmetic:
  - If in_shift >= SIG_W (saturation): result = 0, and sticky = |in_sig2.
  - Otherwise the shift runs as a log shifter. Level k shifts right by 2^k when shift bit k is set. Bits lost at each level are ORed into a running sticky.
  - Saturation is decided from the full EXP_W shift value in stage 0, not from truncated bits.
- Final output: out_sig2_aligned = shifted_value | {SIG_W-1 zeros, sticky}. out_sticky = sticky.
- Pipelining: the LVL levels are split across STAGES. Stage s performs levels ceil(s*LVL/STAGES) .. ceil((s+1)*LVL/STAGES)-1. Each stage registers the partial value, running sticky, remaining shift bits, sig1 and tag.
- Boundary values:
  - in_shift=0: sig2 unchanged, sticky=0.
  - in_shift=SIG_W-1: only the MSB can survive.
  - in_sig2=0: sticky=0 for any shift.
- Simultaneous accept and output handshake in the same cycle is legal and is the full-throughput case.
- in_shift bits above LVL matter only for saturation detection.

Decomposition:
- Package addpkg holds:
  - constants SIG_W_DEF=27, EXP_W_DEF=8;
  - typedef align_stage_t: a struct of valid, sig1, partial, sticky, shift remainder and tag, used for the per-stage registers.
- Sub-module align_shift_level:
  - combinational, one log-shifter level;
  - parameters SIG_W and AMT (shift amount 2^k);
  - inputs data, en, sticky_in; outputs data_out, sticky_out;
  - instantiated LVL times through a generate loop.

Test Plan (SIG_W=27, EXP_W=8, STAGES=1 and STAGES=3 both run):
- sig2=27'h4000000, shift=3 -> aligned=27'h0800000, sticky=0; out_valid exactly STAGES cycles after accept.
- sig2=27'h4000004, shift=2 -> 27'h1000001, sticky=0. sig2=27'h4000002, shift=2 -> 27'h1000001, sticky=1 (sticky ORed into bit 0).
- Saturation: sig2=27'h4000000, shift=200 -> 27'h0000001, sticky=1. sig2=0, shift=200 -> 0, sticky=0. shift=27 -> same as saturation. shift=0 -> sig2 unchanged.
- Back-to-back stream of 10 requests with distinct tags 0..9, out_ready held low for cycles 4-8:
  - outputs stay stable while stalled;
  - in_ready=0 during the stall;
  - all 10 tags come out in order with no loss or duplication;
  - sig1 passes through unmodified.
- Reset asserted asynchronously (mid-cycle) with 3 requests in flight -> out_valid drops immediately, in_ready=1 after reset release, no stale result appears afterwards.
- Random regression of 10k requests against a reference model (shift with sticky OR), including random out_ready toggling.
